// File: rtl/fsm_arbiter_n_if.sv
// fsm_arbiter_n_if: request/grant bundle between bus masters and the arbiter
interface fsm_arbiter_n_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
);
  logic             mode;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             preempt;
  modport master (output mode, req, input gnt, gnt_valid, gnt_idx, preempt);
  modport slave  (input mode, req, output gnt, gnt_valid, gnt_idx, preempt);
endinterface

// File: rtl/fsm_arbiter_n.sv
// fsm_arbiter_n: N-way fixed-priority/round-robin grant FSM with optional hold-limit preemption
module fsm_arbiter_n #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 0,
  parameter int IDX_W    = $clog2(N_REQ)
) (
  input logic             clock,
  input logic             reset,
  fsm_arbiter_n_if.slave  bus
);
  localparam int HW = $clog2(HOLD_MAX + 1) > 1 ? $clog2(HOLD_MAX + 1) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state, state_n;
  logic [HW-1:0]    hold_cnt, cnt_n;
  logic [IDX_W-1:0] last_idx, last_n, win, idx_n;
  logic [N_REQ-1:0] gnt_n;
  logic             pre_n;
  int               k;
  always_comb begin
    win = '0;
    k = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = bus.mode ? (int'(last_idx) + 1 + i) % N_REQ : i;
      if (bus.req[k]) win = IDX_W'(k);
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = hold_cnt;
    last_n = last_idx;
    gnt_n = '0;
    idx_n = '0;
    pre_n = 1'b0;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_n = GRANT;
        gnt_n[win] = 1'b1;
        idx_n = win;
        last_n = win;
        cnt_n = '0;
      end
    end else if (!bus.req[last_idx]) begin
      state_n = IDLE;
    end else if (HOLD_MAX != 0 && hold_cnt == HW'(HOLD_MAX - 1)) begin
      state_n = IDLE;
      pre_n = 1'b1;
    end else begin
      gnt_n = bus.gnt;
      idx_n = bus.gnt_idx;
      cnt_n = HOLD_MAX != 0 ? hold_cnt + 1'b1 : hold_cnt;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      last_idx <= IDX_W'(N_REQ - 1);
      bus.gnt <= '0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_idx <= '0;
      bus.preempt <= 1'b0;
    end else begin
      state <= state_n;
      hold_cnt <= cnt_n;
      last_idx <= last_n;
      bus.gnt <= gnt_n;
      bus.gnt_valid <= |gnt_n;
      bus.gnt_idx <= idx_n;
      bus.preempt <= pre_n;
    end
  end
endmodule

// File: tb/tb_fsm_arbiter_n.sv
// tb_fsm_arbiter_n: directed vector tables plus randomized model comparison over three configurations
module tb_fsm_arbiter_n;
  typedef struct {
    bit         r;
    bit         m;
    logic [7:0] q;
    logic [7:0] eg;
    int         ei;
    bit         ep;
  } vec_t;
  logic       clock;
  logic [2:0] rst;
  int         checks, errors;
  fsm_arbiter_n_if #(.N_REQ(4)) ia();
  fsm_arbiter_n_if #(.N_REQ(4)) ib();
  fsm_arbiter_n_if #(.N_REQ(8)) ic();
  fsm_arbiter_n #(.N_REQ(4), .HOLD_MAX(0)) u_a (.clock(clock), .reset(rst[0]), .bus(ia));
  fsm_arbiter_n #(.N_REQ(4), .HOLD_MAX(3)) u_b (.clock(clock), .reset(rst[1]), .bus(ib));
  fsm_arbiter_n #(.N_REQ(8), .HOLD_MAX(5)) u_c (.clock(clock), .reset(rst[2]), .bus(ic));
  logic [31:0] g [3];
  logic [31:0] ix [3];
  logic        v [3];
  logic        p [3];
  assign g[0] = 32'(ia.gnt);
  assign g[1] = 32'(ib.gnt);
  assign g[2] = 32'(ic.gnt);
  assign ix[0] = 32'(ia.gnt_idx);
  assign ix[1] = 32'(ib.gnt_idx);
  assign ix[2] = 32'(ic.gnt_idx);
  assign v[0] = ia.gnt_valid;
  assign v[1] = ib.gnt_valid;
  assign v[2] = ic.gnt_valid;
  assign p[0] = ia.preempt;
  assign p[1] = ib.preempt;
  assign p[2] = ic.preempt;
  int nn [3] = '{4, 4, 8};
  int hh [3] = '{0, 3, 5};
  int own [3];
  int held [3];
  int last [3];
  bit pre [3];
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(int d, bit r, bit m, logic [7:0] q);
    rst[d] = r;
    if (d == 0) begin
      ia.mode = m;
      ia.req = q[3:0];
    end else if (d == 1) begin
      ib.mode = m;
      ib.req = q[3:0];
    end else begin
      ic.mode = m;
      ic.req = q;
    end
  endtask
  task automatic chk(int d, logic [31:0] eg, int ei, bit ep, string name);
    checks++;
    if (g[d] !== eg || ix[d] !== 32'(ei) || v[d] !== (eg != 0) || p[d] !== ep) begin
      errors++;
      $display("FAIL %s dut%0d: got gnt=%0h idx=%0d valid=%0b preempt=%0b, want gnt=%0h idx=%0d valid=%0b preempt=%0b",
               name, d, g[d], ix[d], v[d], p[d], eg, ei, eg != 0, ep);
    end
  endtask
  task automatic run_table(int d, input vec_t t[$], string name);
    foreach (t[i]) begin
      drive(d, t[i].r, t[i].m, t[i].q);
      tick();
      chk(d, 32'(t[i].eg), t[i].ei, t[i].ep, $sformatf("%s[%0d]", name, i));
    end
  endtask
  function automatic vec_t mk(bit r, bit m, logic [7:0] q, logic [7:0] eg, int ei, bit ep);
    vec_t x;
    x.r = r;
    x.m = m;
    x.q = q;
    x.eg = eg;
    x.ei = ei;
    x.ep = ep;
    return x;
  endfunction
  // Reference: who owns the resource, how long they have held it, and who won last.
  task automatic mstep(int d, bit r, bit m, logic [7:0] q);
    int w;
    if (r) begin
      own[d] = -1;
      held[d] = 0;
      last[d] = nn[d] - 1;
      pre[d] = 1'b0;
    end else if (own[d] < 0) begin
      pre[d] = 1'b0;
      w = -1;
      for (int i = 0; i < nn[d]; i++) begin
        int kk;
        kk = m ? (last[d] + 1 + i) % nn[d] : i;
        if (w < 0 && q[kk]) w = kk;
      end
      if (w >= 0) begin
        own[d] = w;
        last[d] = w;
        held[d] = 1;
      end
    end else begin
      pre[d] = 1'b0;
      if (!q[own[d]]) own[d] = -1;
      else if (hh[d] > 0 && held[d] == hh[d]) begin
        own[d] = -1;
        pre[d] = 1'b1;
      end else held[d]++;
    end
  endtask
  task automatic chk_model(int d);
    chk(d, own[d] < 0 ? 32'd0 : 32'd1 << own[d], own[d] < 0 ? 0 : own[d], pre[d], "random");
  endtask
  vec_t ta[$];
  vec_t tb[$];
  logic [7:0] qr [3];
  bit mr [3];
  initial begin
    checks = 0;
    errors = 0;
    rst = 3'b111;
    for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b0, 8'h00);
    repeat (3) ta.push_back(mk(1, 0, 8'hF, 8'h0, 0, 0));
    repeat (2) ta.push_back(mk(0, 0, 8'h0, 8'h0, 0, 0));
    ta.push_back(mk(0, 0, 8'hA, 8'h2, 1, 0));
    ta.push_back(mk(0, 0, 8'hA, 8'h2, 1, 0));
    ta.push_back(mk(0, 0, 8'h8, 8'h0, 0, 0));
    ta.push_back(mk(0, 0, 8'h8, 8'h8, 3, 0));
    ta.push_back(mk(0, 0, 8'h0, 8'h0, 0, 0));
    ta.push_back(mk(0, 1, 8'hF, 8'h1, 0, 0));
    ta.push_back(mk(0, 1, 8'hE, 8'h0, 0, 0));
    ta.push_back(mk(0, 1, 8'hF, 8'h2, 1, 0));
    ta.push_back(mk(0, 1, 8'hD, 8'h0, 0, 0));
    ta.push_back(mk(0, 1, 8'hF, 8'h4, 2, 0));
    ta.push_back(mk(0, 1, 8'hB, 8'h0, 0, 0));
    ta.push_back(mk(0, 1, 8'hF, 8'h8, 3, 0));
    ta.push_back(mk(0, 0, 8'hF, 8'h8, 3, 0));
    ta.push_back(mk(0, 1, 8'h7, 8'h0, 0, 0));
    ta.push_back(mk(0, 1, 8'hF, 8'h1, 0, 0));
    ta.push_back(mk(0, 1, 8'h0, 8'h0, 0, 0));
    run_table(0, ta, "tbl_a");
    rst[0] = 1'b1;
    tb.push_back(mk(1, 1, 8'h3, 8'h0, 0, 0));
    for (int rep = 0; rep < 2; rep++) begin
      repeat (3) tb.push_back(mk(0, 1, 8'h3, 8'h1, 0, 0));
      tb.push_back(mk(0, 1, 8'h3, 8'h0, 0, 1));
      if (rep == 0) begin
        repeat (3) tb.push_back(mk(0, 1, 8'h3, 8'h2, 1, 0));
        tb.push_back(mk(0, 1, 8'h3, 8'h0, 0, 1));
      end
    end
    tb.push_back(mk(0, 1, 8'h3, 8'h2, 1, 0));
    tb.push_back(mk(0, 1, 8'h3, 8'h2, 1, 0));
    tb.push_back(mk(0, 1, 8'h3, 8'h2, 1, 0));
    tb.push_back(mk(0, 1, 8'h1, 8'h0, 0, 0));
    tb.push_back(mk(0, 1, 8'h1, 8'h1, 0, 0));
    tb.push_back(mk(0, 1, 8'h0, 8'h0, 0, 0));
    repeat (3) tb.push_back(mk(0, 0, 8'h1, 8'h1, 0, 0));
    tb.push_back(mk(0, 0, 8'h1, 8'h0, 0, 1));
    tb.push_back(mk(0, 0, 8'h1, 8'h1, 0, 0));
    tb.push_back(mk(0, 0, 8'h0, 8'h0, 0, 0));
    run_table(1, tb, "tbl_b");
    rst[1] = 1'b1;
    drive(2, 1'b1, 1'b1, 8'h00);
    tick();
    chk(2, 0, 0, 0, "c_reset");
    drive(2, 1'b0, 1'b1, 8'h40);
    tick();
    chk(2, 32'h40, 6, 0, "c_grant6");
    tick();
    chk(2, 32'h40, 6, 0, "c_hold6");
    drive(2, 1'b1, 1'b1, 8'hFF);
    tick();
    chk(2, 0, 0, 0, "c_midreset");
    drive(2, 1'b0, 1'b1, 8'hFF);
    tick();
    chk(2, 32'h01, 0, 0, "c_rr_after_reset");
    for (int d = 0; d < 3; d++) begin
      qr[d] = 8'h00;
      mr[d] = 1'b0;
      drive(d, 1'b1, 1'b0, 8'h00);
      mstep(d, 1'b1, 1'b0, 8'h00);
    end
    tick();
    for (int d = 0; d < 3; d++) chk_model(d);
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < 3; d++) begin
        bit rr;
        if ($urandom_range(0, 3) == 0) qr[d] = 8'($urandom) & (nn[d] == 8 ? 8'hFF : 8'h0F);
        if ($urandom_range(0, 15) == 0) mr[d] = ~mr[d];
        rr = $urandom_range(0, 199) == 0;
        drive(d, rr, mr[d], qr[d]);
        mstep(d, rr, mr[d], qr[d]);
      end
      tick();
      for (int d = 0; d < 3; d++) chk_model(d);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
